// File: rtl/whack_pkg.sv
// Shared constants and the per-slot event type for the mole board.
// No logic here; latency and backpressure are not applicable.
package whack_pkg;

  localparam int N_HOLES_DEF = 5;
  localparam int LIFE_W_DEF  = 8;
  localparam int SCORE_W_DEF = 10;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_HIT,
    SLOT_EXPIRE,
    SLOT_LOAD
  } slot_evt_e;

endpackage

// File: rtl/mole_board_if.sv
// Scheduler/display-facing signal bundle of mole_board; whiff_trigger exists only
// with MOLE_WHIFF_PENALTY_EN. Pure wiring: no latency, no backpressure.
interface mole_board_if import whack_pkg::*; #(
  parameter int N_HOLES = N_HOLES_DEF,
  parameter int LIFE_W  = LIFE_W_DEF,
  parameter int SCORE_W = SCORE_W_DEF
) ();

  localparam int CNT_W = $clog2(N_HOLES + 1);

  logic               tick;
  logic               load;
  logic [N_HOLES-1:0] load_mask;
  logic [LIFE_W-1:0]  load_life;
  logic [N_HOLES-1:0] button;
  logic               clear_score;
  logic [N_HOLES-1:0] board_state;
  logic               score_trigger;
  logic [CNT_W-1:0]   hit_count;
  logic               miss_trigger;
  logic [SCORE_W-1:0] score;

`ifdef MOLE_WHIFF_PENALTY_EN
  logic               whiff_trigger;

  modport master (
    output tick, load, load_mask, load_life, button, clear_score,
    input  board_state, score_trigger, hit_count, miss_trigger, score, whiff_trigger
  );
  modport slave (
    input  tick, load, load_mask, load_life, button, clear_score,
    output board_state, score_trigger, hit_count, miss_trigger, score, whiff_trigger
  );
`else
  modport master (
    output tick, load, load_mask, load_life, button, clear_score,
    input  board_state, score_trigger, hit_count, miss_trigger, score
  );
  modport slave (
    input  tick, load, load_mask, load_life, button, clear_score,
    output board_state, score_trigger, hit_count, miss_trigger, score
  );
`endif

endinterface

// File: rtl/mole_slot.sv
// One hole: presence flag, lifetime countdown and button edge detect; events resolve
// hit > expire > load on the same edge. Event/whiff are combinational; no backpressure.
module mole_slot import whack_pkg::*; #(
  parameter int LIFE_W = LIFE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              load_i,
  input  logic [LIFE_W-1:0] load_life_i,
  input  logic              button_i,
  output logic              active_o,
  output slot_evt_e         evt_o,
  output logic              whiff_o
);

  logic              active_q, active_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic              btn_q;
  logic              hit_raw, valid_hit, expire, do_load;

  always_comb begin
    hit_raw   = button_i & ~btn_q;
    valid_hit = hit_raw & active_q;
    expire    = active_q & tick_i & (life_q == LIFE_W'(1)) & ~valid_hit;
    do_load   = load_i & (load_life_i != '0) & ~valid_hit & ~expire;
    active_d  = active_q;
    life_d    = life_q;
    evt_o     = SLOT_IDLE;
    if (valid_hit) begin
      active_d = 1'b0;
      life_d   = '0;
      evt_o    = SLOT_HIT;
    end else if (expire) begin
      active_d = 1'b0;
      life_d   = '0;
      evt_o    = SLOT_EXPIRE;
    end else if (do_load) begin
      // a reload of a live mole restarts its lifetime
      active_d = 1'b1;
      life_d   = load_life_i;
      evt_o    = SLOT_LOAD;
    end else if (active_q && tick_i) begin
      life_d = life_q - LIFE_W'(1);
    end
  end

  // judged on pre-load state, so a press on a slot being loaded still whiffs
  assign whiff_o  = hit_raw & ~active_q;
  assign active_o = active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      life_q   <= '0;
      btn_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      life_q   <= life_d;
      btn_q    <= button_i;
    end
  end

endmodule

// File: rtl/mole_board.sv
// N_HOLES mole slots with registered hit/miss pulses, hit count and saturating score;
// results appear one edge after the press. No backpressure. Option: MOLE_WHIFF_PENALTY_EN.
module mole_board import whack_pkg::*; #(
  parameter int N_HOLES = N_HOLES_DEF,
  parameter int LIFE_W  = LIFE_W_DEF,
  parameter int SCORE_W = SCORE_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  mole_board_if.slave bus
);

  localparam int CNT_W = $clog2(N_HOLES + 1);

  slot_evt_e          evt [N_HOLES];
  logic [N_HOLES-1:0] active;
  logic [N_HOLES-1:0] whiff;

  logic [CNT_W-1:0]   hit_cnt_d, hit_cnt_q;
  logic               miss_d, miss_q;
  logic               score_trig_q;
  logic [SCORE_W-1:0] score_d, score_q;

  for (genvar g = 0; g < N_HOLES; g++) begin : g_slot
    mole_slot #(.LIFE_W(LIFE_W)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (bus.tick),
      .load_i      (bus.load & bus.load_mask[g]),
      .load_life_i (bus.load_life),
      .button_i    (bus.button[g]),
      .active_o    (active[g]),
      .evt_o       (evt[g]),
      .whiff_o     (whiff[g])
    );
  end

`ifdef MOLE_WHIFF_PENALTY_EN
  logic [CNT_W-1:0]   whiff_cnt_d;
  logic               whiff_q;
  logic [SCORE_W+1:0] sum;

  always_comb begin
    whiff_cnt_d = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      if (whiff[i]) whiff_cnt_d = whiff_cnt_d + CNT_W'(1);
    end
  end
`else
  logic [SCORE_W:0] sum;
  logic             unused_whiff;

  assign unused_whiff = ^whiff;
`endif

  always_comb begin
    hit_cnt_d = '0;
    miss_d    = 1'b0;
    for (int i = 0; i < N_HOLES; i++) begin
      if (evt[i] == SLOT_HIT)    hit_cnt_d = hit_cnt_d + CNT_W'(1);
      if (evt[i] == SLOT_EXPIRE) miss_d    = 1'b1;
    end
`ifdef MOLE_WHIFF_PENALTY_EN
    // two's-complement in SCORE_W+2 bits: MSB set means negative, next bit means overflow
    sum = (SCORE_W+2)'(score_q) + (SCORE_W+2)'(hit_cnt_d) - (SCORE_W+2)'(whiff_cnt_d);
    if (sum[SCORE_W+1])    score_d = '0;
    else if (sum[SCORE_W]) score_d = '1;
    else                   score_d = sum[SCORE_W-1:0];
`else
    sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(hit_cnt_d);
    score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
`endif
    if (bus.clear_score) score_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q    <= '0;
      miss_q       <= 1'b0;
      score_trig_q <= 1'b0;
      score_q      <= '0;
`ifdef MOLE_WHIFF_PENALTY_EN
      whiff_q      <= 1'b0;
`endif
    end else begin
      hit_cnt_q    <= hit_cnt_d;
      miss_q       <= miss_d;
      score_trig_q <= (hit_cnt_d != '0);
      score_q      <= score_d;
`ifdef MOLE_WHIFF_PENALTY_EN
      whiff_q      <= |whiff;
`endif
    end
  end

  assign bus.board_state   = active;
  assign bus.hit_count     = hit_cnt_q;
  assign bus.score_trigger = score_trig_q;
  assign bus.miss_trigger  = miss_q;
  assign bus.score         = score_q;
`ifdef MOLE_WHIFF_PENALTY_EN
  assign bus.whiff_trigger = whiff_q;
`endif

endmodule

// File: tb/tb_mole_board.sv
// Directed scenarios plus random play against an array-based game model.
module tb_mole_board;
  import whack_pkg::*;

  localparam int N    = 5;
  localparam int LW   = 8;
  localparam int SW   = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mole_board_if #(.N_HOLES(N), .LIFE_W(LW), .SCORE_W(SW)) bus ();

  mole_board #(.N_HOLES(N), .LIFE_W(LW), .SCORE_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: remaining visible ticks per hole (0 = empty) and last button levels
  int life [N];
  bit prev [N];
  int m_hits, m_score;
  bit m_miss, m_whiff;
  logic [N-1:0] btn;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_board();
    int v = 0;
    for (int i = 0; i < N; i++) if (life[i] > 0) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      life[i] = 0;
      prev[i] = 1'b0;
    end
    m_hits = 0; m_score = 0; m_miss = 0; m_whiff = 0;
  endtask

  task automatic model_step(input bit t, input bit ld, input logic [N-1:0] m,
                            input int l, input logic [N-1:0] b, input bit clr);
    int wh = 0;
    int s;
    m_hits = 0;
    m_miss = 0;
    for (int i = 0; i < N; i++) begin
      bit rise = b[i] && !prev[i];
      prev[i] = b[i];
      if (rise && life[i] == 0) wh++;
      if (rise && life[i] > 0) begin
        m_hits++;
        life[i] = 0;
      end else if (t && life[i] == 1) begin
        m_miss = 1;
        life[i] = 0;
      end else begin
        if (t && life[i] > 1) life[i]--;
        if (ld && m[i] && l != 0) life[i] = l;
      end
    end
    m_whiff = (wh != 0);
`ifdef MOLE_WHIFF_PENALTY_EN
    s = m_score + m_hits - wh;
    if (s < 0) s = 0;
`else
    s = m_score + m_hits;
`endif
    if (s > SMAX) s = SMAX;
    if (clr) s = 0;
    m_score = s;
  endtask

  task automatic check_all();
    check("board", 32'(bus.board_state), model_board());
    check("hit_count", 32'(bus.hit_count), m_hits);
    check("score_trig", 32'(bus.score_trigger), 32'(m_hits != 0));
    check("miss_trig", 32'(bus.miss_trigger), 32'(m_miss));
    check("score", 32'(bus.score), m_score);
`ifdef MOLE_WHIFF_PENALTY_EN
    check("whiff_trig", 32'(bus.whiff_trigger), 32'(m_whiff));
`endif
  endtask

  // called at a negedge: apply inputs, cross one posedge, check at the next negedge
  task automatic drive(input bit t, input bit ld, input logic [N-1:0] m, input int l,
                       input logic [N-1:0] b, input bit clr);
    bus.tick        = t;
    bus.load        = ld;
    bus.load_mask   = m;
    bus.load_life   = LW'(l);
    bus.button      = b;
    bus.clear_score = clr;
    btn = b;
    model_step(t, ld, m, l, b, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic [N-1:0] b);
    drive(1'b0, 1'b0, '0, 0, b, 1'b0);
  endtask

  initial begin
    bus.tick = 0; bus.load = 0; bus.load_mask = '0; bus.load_life = '0;
    bus.button = '0; bus.clear_score = 0;
    btn = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_board", 32'(bus.board_state), 0);
    check("reset_score", 32'(bus.score), 0);
    rst_n = 1'b1;
    check_all();

    // single hit on hole 2
    drive(1, 1, 5'b00100, 4, '0, 0);
    drive(1, 0, '0, 0, '0, 0);
    drive(1, 0, '0, 0, 5'b00100, 0);
    check("hit_board", 32'(bus.board_state), 0);
    check("hit_cnt1", 32'(bus.hit_count), 1);
    check("hit_trig", 32'(bus.score_trigger), 1);
    check("hit_score", 32'(bus.score), 1);
    drive(1, 0, '0, 0, 5'b00100, 0);
    check("hit_trig_pulse", 32'(bus.score_trigger), 0);
    idle('0);

    // expiry with a tick every cycle
    drive(1, 1, 5'b00001, 3, '0, 0);
    drive(1, 0, '0, 0, '0, 0);
    drive(1, 0, '0, 0, '0, 0);
    check("exp_alive", 32'(bus.board_state[0]), 1);
    drive(1, 0, '0, 0, '0, 0);
    check("exp_gone", 32'(bus.board_state[0]), 0);
    check("exp_miss", 32'(bus.miss_trigger), 1);
    check("exp_score", 32'(bus.score), 1);
    idle('0);
    check("exp_miss_pulse", 32'(bus.miss_trigger), 0);

    // expiry with a tick every 4th cycle
    drive(0, 1, 5'b00001, 3, '0, 0);
    for (int k = 0; k < 12; k++) begin
      drive(k % 4 == 3, 0, '0, 0, '0, 0);
      if (k == 10) check("exp4_alive", 32'(bus.board_state[0]), 1);
    end
    check("exp4_miss", 32'(bus.miss_trigger), 1);
    check("exp4_gone", 32'(bus.board_state[0]), 0);

    // multi-hit, then held button across a reload
    drive(0, 1, 5'b11111, 100, '0, 0);
    drive(0, 0, '0, 0, 5'b10011, 0);
    check("multi_cnt", 32'(bus.hit_count), 3);
    check("multi_board", 32'(bus.board_state), 5'b01100);
    drive(0, 0, '0, 0, 5'b10111, 0);
    drive(0, 1, 5'b00100, 100, 5'b10111, 0);
    check("held_load", 32'(bus.board_state[2]), 1);
    check("held_nohit", 32'(bus.hit_count), 0);
    drive(0, 0, '0, 0, 5'b10111, 0);
    check("held_nohit2", 32'(bus.hit_count), 0);
    drive(0, 0, '0, 0, 5'b10011, 0);
    drive(0, 0, '0, 0, 5'b10111, 0);
    check("repress_hit", 32'(bus.hit_count), 1);
    idle('0);

    // collisions
    drive(0, 1, 5'b01000, 9, '0, 0);
    drive(0, 1, 5'b01000, 9, 5'b01000, 0);
    check("hitload_cnt", 32'(bus.hit_count), 1);
    check("hitload_clr", 32'(bus.board_state[3]), 0);
    drive(0, 1, 5'b11111, 0, 5'b01000, 0);
    check("life0_board", 32'(bus.board_state), 0);
    drive(0, 1, 5'b00001, 1, '0, 0);
    drive(1, 1, 5'b00001, 5, '0, 0);
    check("exprel_miss", 32'(bus.miss_trigger), 1);
    check("exprel_clr", 32'(bus.board_state[0]), 0);

    // saturation and clear priority
    drive(0, 1, 5'b11111, 50, '0, 1);
    drive(0, 0, '0, 0, 5'b11111, 0);
    drive(0, 1, 5'b11111, 50, '0, 0);
    drive(0, 0, '0, 0, 5'b11111, 0);
    check("sat_score", 32'(bus.score), SMAX);
    drive(0, 1, 5'b00001, 50, '0, 0);
    drive(0, 0, '0, 0, 5'b00001, 1);
    check("clr_hit_cnt", 32'(bus.hit_count), 1);
    check("clr_score", 32'(bus.score), 0);

`ifdef MOLE_WHIFF_PENALTY_EN
    idle('0);
    drive(0, 1, 5'b00001, 50, '0, 0);
    drive(0, 0, '0, 0, 5'b00001, 0);
    check("pen_score1", 32'(bus.score), 1);
    drive(0, 0, '0, 0, 5'b00111, 0);
    check("pen_score0", 32'(bus.score), 0);
    check("pen_whiff", 32'(bus.whiff_trigger), 1);
`endif

    // asynchronous reset in mid-game
    idle('0);
    drive(0, 1, 5'b10111, 20, '0, 1);
    drive(0, 0, '0, 0, 5'b00010, 0);
    check("mid_board", 32'(bus.board_state), 5'b10101);
    #2 rst_n = 1'b0;
    #1;
    check("arst_board", 32'(bus.board_state), 0);
    check("arst_score", 32'(bus.score), 0);
    check("arst_hits", 32'(bus.hit_count), 0);
    check("arst_trig", 32'(bus.score_trigger), 0);
    model_reset();
    bus.button = '0;
    btn = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle('0);

    // random play
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] b = btn ^ N'($urandom & $urandom);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, N'($urandom),
            $urandom_range(0, 6), b, $urandom_range(0, 31) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
